// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU / multiply-divide unit.
// Contents: default datapath width, aluOp codes, funct3 codes for the
// integer ALU, the M extension and branch compares, and the handshake
// FSM state encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_FUNC = 3'b010;
  localparam logic [2:0] ALUOP_BR   = 3'b011;

  // Integer ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // M extension funct3
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULHU  = 3'd3;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Operation/result handshake bundle between the ID/EX register, the
// ALU/MDU and the EX/MEM register.
//   master : issues operations (in_valid, operands, aluOp, func, flush)
//            and consumes results (out_ready)
//   slave  : the ALU/MDU (in_ready, out_valid, aluResult, branchTaken,
//            divByZero)
interface alu_mdu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [2:0]       aluOp;
  logic [4:0]       func;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluResult;
  logic             branchTaken;
  logic             divByZero;

  modport master (
    output in_valid, dataA, dataB, aluOp, func, flush, out_ready,
    input  in_ready, out_valid, aluResult, branchTaken, divByZero
  );

  modport slave (
    input  in_valid, dataA, dataB, aluOp, func, flush, out_ready,
    output in_ready, out_valid, aluResult, branchTaken, divByZero
  );
endinterface

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply / divide datapath, one bit per cycle.
// Operands arrive as magnitudes; sign handling lives in the caller.
//   clk, reset, flush : clock, sync reset, kill of the running operation
//   start             : load operands and begin WIDTH iterations
//   is_div            : divide instead of multiply (ALU_MDU_DIV_EN only)
//   op_a, op_b        : multiplier/dividend, multiplicand/divisor
//   done              : high during the final iteration cycle
//   hi, lo            : next-state values; at done they hold the final
//                       {product_hi, product_lo} or {remainder, quotient}
// Macro ALU_MDU_DIV_EN builds the restoring divider.
module alu_mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
`ifdef ALU_MDU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_r, lo_r, b_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] hi_n_s, lo_n_s;
  logic             done_s;
`ifdef ALU_MDU_DIV_EN
  logic             div_r;
  logic [WIDTH:0]   sh_s, diff_s;
`endif

  // One shift-add multiply step or one restoring divide step.
  always_comb begin
    sum_s = lo_r[0] ? ({1'b0, hi_r} + {1'b0, b_r}) : {1'b0, hi_r};
`ifdef ALU_MDU_DIV_EN
    sh_s   = {hi_r, lo_r[WIDTH-1]};
    diff_s = sh_s - {1'b0, b_r};
    if (div_r) begin
      // No borrow: divisor fits, keep the difference and set the quotient bit.
      hi_n_s = diff_s[WIDTH] ? sh_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
      lo_n_s = {lo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    end else begin
      hi_n_s = sum_s[WIDTH:1];
      lo_n_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
`else
    hi_n_s = sum_s[WIDTH:1];
    lo_n_s = {sum_s[0], lo_r[WIDTH-1:1]};
`endif
  end

  assign done_s = busy_r && (cnt_r == CW'(WIDTH - 1));
  assign done   = done_s;
  assign hi     = hi_n_s;
  assign lo     = lo_n_s;

  // Operand load, iteration and counter registers.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      busy_r <= 1'b0;
      cnt_r  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      b_r    <= '0;
`ifdef ALU_MDU_DIV_EN
      div_r  <= 1'b0;
`endif
    end else if (start) begin
      busy_r <= 1'b1;
      cnt_r  <= '0;
      hi_r   <= '0;
      lo_r   <= op_a;
      b_r    <= op_b;
`ifdef ALU_MDU_DIV_EN
      div_r  <= is_div;
`endif
    end else if (busy_r) begin
      hi_r  <= hi_n_s;
      lo_r  <= lo_n_s;
      cnt_r <= cnt_r + CW'(1);
      if (done_s) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// EX-stage ALU with iterative RV32M multiply (and optional divide) and
// B-type branch resolution, behind valid/ready handshakes.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : alu_mdu_seq_if.slave (operation in, result out, flush)
// Single-cycle ops deliver one result per cycle; MUL* (and DIV*/REM*)
// take WIDTH iteration cycles in alu_mdu_iter.
// Macro ALU_MDU_DIV_EN: build the divider. Without it, DIV/DIVU/REM/REMU
// complete in one cycle with result 0 and divByZero 0.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             reset,
  alu_mdu_seq_if.slave    bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_r;
  logic               out_valid_r, br_r, dbz_r, neg_r;
  logic [WIDTH-1:0]   result_r;
  logic [2:0]         op_r;
`ifdef ALU_MDU_DIV_EN
  logic               sa_r;
`endif

  logic [2:0]         f3_s;
  logic               mext_s, alt_s, accept_s, start_s;
  logic [SHW-1:0]     shamt_s;
  logic [WIDTH-1:0]   single_res_s, mag_a_s, mag_b_s, iter_res_s;
  logic [WIDTH-1:0]   iter_hi_s, iter_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               single_br_s, single_dbz_s, go_mul_s, go_div_s;
  logic               sgn_a_s, sgn_b_s, iter_done_s;

  assign f3_s    = bus.func[2:0];
  assign alt_s   = bus.func[3];
  assign mext_s  = bus.func[4];
  assign shamt_s = bus.dataB[SHW-1:0];

  // DONE is IDLE with a result pending, so single ops can stream 1/cycle.
  assign bus.in_ready = ((state_r == ST_IDLE) || (state_r == ST_DONE)) &&
                        (!out_valid_r || bus.out_ready) && !reset;
  assign accept_s = bus.in_valid && bus.in_ready;
  assign start_s  = accept_s && !bus.flush && (go_mul_s || go_div_s);

  assign bus.out_valid   = out_valid_r;
  assign bus.aluResult   = result_r;
  assign bus.branchTaken = br_r;
  assign bus.divByZero   = dbz_r;

  // Single-cycle result, branch decision and iterative-op dispatch.
  always_comb begin
    single_res_s = '0;
    single_br_s  = 1'b0;
    single_dbz_s = 1'b0;
    go_mul_s     = 1'b0;
    go_div_s     = 1'b0;
    case (bus.aluOp)
      ALUOP_ADD: single_res_s = bus.dataA + bus.dataB;
      ALUOP_SUB: single_res_s = bus.dataA - bus.dataB;
      ALUOP_FUNC: begin
        if (!mext_s) begin
          case (f3_s)
            F3_ADD:  single_res_s = alt_s ? bus.dataA - bus.dataB : bus.dataA + bus.dataB;
            F3_SLL:  single_res_s = bus.dataA << shamt_s;
            F3_SLT:  single_res_s = {{(WIDTH-1){1'b0}}, $signed(bus.dataA) < $signed(bus.dataB)};
            F3_SLTU: single_res_s = {{(WIDTH-1){1'b0}}, bus.dataA < bus.dataB};
            F3_XOR:  single_res_s = bus.dataA ^ bus.dataB;
            F3_SR:   single_res_s = alt_s ? $unsigned($signed(bus.dataA) >>> shamt_s)
                                          : bus.dataA >> shamt_s;
            F3_OR:   single_res_s = bus.dataA | bus.dataB;
            F3_AND:  single_res_s = bus.dataA & bus.dataB;
            default: single_res_s = '0;
          endcase
        end else if (!f3_s[2]) begin
          go_mul_s = 1'b1;
        end else begin
`ifdef ALU_MDU_DIV_EN
          // Zero divisor and MIN/-1 are answered without iterating.
          if (bus.dataB == '0) begin
            single_dbz_s = 1'b1;
            single_res_s = f3_s[1] ? bus.dataA : '1;
          end else if (!f3_s[0] && (bus.dataA == INT_MIN) && (bus.dataB == '1)) begin
            single_res_s = f3_s[1] ? '0 : INT_MIN;
          end else begin
            go_div_s = 1'b1;
          end
`else
          single_res_s = '0;
`endif
        end
      end
      ALUOP_BR: begin
        case (f3_s)
          F3_BEQ:  single_br_s = (bus.dataA == bus.dataB);
          F3_BNE:  single_br_s = (bus.dataA != bus.dataB);
          F3_BLT:  single_br_s = ($signed(bus.dataA) <  $signed(bus.dataB));
          F3_BGE:  single_br_s = ($signed(bus.dataA) >= $signed(bus.dataB));
          F3_BLTU: single_br_s = (bus.dataA <  bus.dataB);
          F3_BGEU: single_br_s = (bus.dataA >= bus.dataB);
          default: single_br_s = 1'b0;
        endcase
      end
      default: single_res_s = '0;
    endcase
  end

  // Operand signedness and magnitudes for the unsigned iterative core.
  always_comb begin
    if (!f3_s[2]) begin
      sgn_a_s = (f3_s != F3_MULHU) && bus.dataA[WIDTH-1];
      sgn_b_s = !f3_s[1] && bus.dataB[WIDTH-1];
    end else begin
      sgn_a_s = !f3_s[0] && bus.dataA[WIDTH-1];
      sgn_b_s = !f3_s[0] && bus.dataB[WIDTH-1];
    end
    mag_a_s = sgn_a_s ? -bus.dataA : bus.dataA;
    mag_b_s = sgn_b_s ? -bus.dataB : bus.dataB;
  end

  alu_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .flush  (bus.flush),
    .start  (start_s),
`ifdef ALU_MDU_DIV_EN
    .is_div (go_div_s),
`endif
    .op_a   (mag_a_s),
    .op_b   (mag_b_s),
    .done   (iter_done_s),
    .hi     (iter_hi_s),
    .lo     (iter_lo_s)
  );

  // Re-apply signs to the iterative result and pick the requested half.
  always_comb begin
    prod_s     = {iter_hi_s, iter_lo_s};
    prod_fix_s = neg_r ? -prod_s : prod_s;
    if (state_r == ST_DIV) begin
`ifdef ALU_MDU_DIV_EN
      if (op_r[1]) begin
        iter_res_s = sa_r ? -iter_hi_s : iter_hi_s;
      end else begin
        iter_res_s = neg_r ? -iter_lo_s : iter_lo_s;
      end
`else
      iter_res_s = '0;
`endif
    end else if (op_r == F3_MUL) begin
      iter_res_s = prod_fix_s[WIDTH-1:0];
    end else begin
      iter_res_s = prod_fix_s[2*WIDTH-1:WIDTH];
    end
  end

  // Handshake FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      br_r        <= 1'b0;
      dbz_r       <= 1'b0;
      op_r        <= 3'b000;
      neg_r       <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      sa_r        <= 1'b0;
`endif
    end else if (bus.flush) begin
      state_r     <= ST_IDLE;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            op_r  <= f3_s;
            neg_r <= sgn_a_s ^ sgn_b_s;
`ifdef ALU_MDU_DIV_EN
            sa_r  <= sgn_a_s;
`endif
            if (go_mul_s) begin
              state_r     <= ST_MUL;
              out_valid_r <= 1'b0;
            end else if (go_div_s) begin
              state_r     <= ST_DIV;
              out_valid_r <= 1'b0;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= single_res_s;
              br_r        <= single_br_s;
              dbz_r       <= single_dbz_s;
            end
          end else if (out_valid_r && bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
          end
        end
        ST_MUL, ST_DIV: begin
          if (iter_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= iter_res_s;
            br_r        <= 1'b0;
            dbz_r       <= 1'b0;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed self-checking bench for alu_mdu_seq (WIDTH 32). Expected values
// are hand-computed; divider expectations follow ALU_MDU_DIV_EN.
module tb_alu_mdu_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;
  logic seen;

  alu_mdu_seq_if #(.WIDTH(W)) bus ();
  alu_mdu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, want);
    end
  endtask

  // Present one operation at a negedge; returns #1 after the accepting edge.
  task automatic launch(input string tag, input logic [2:0] op, input logic [4:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.aluOp = op; bus.func = fn; bus.dataA = a; bus.dataB = b;
    bus.in_valid = 1'b1;
    chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_br, input logic exp_dbz, input int exp_lat);
    int lat;
    lat = 1;
    launch(tag, op, fn, a, b);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, bus.aluResult, exp_res);
    chk({tag, "_flg"}, {30'd0, bus.branchTaken, bus.divByZero}, {30'd0, exp_br, exp_dbz});
  endtask

  task automatic quiet(input string tag, input int cycles);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.dataA = '0; bus.dataB = '0; bus.aluOp = 3'b000;
    bus.func = 5'd0; bus.flush = 1'b0; bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res", bus.aluResult, 32'd0);
    chk("rst_ctl", {28'd0, bus.out_valid, bus.in_ready, bus.branchTaken, bus.divByZero}, 32'd0);
    reset = 1'b0; #1;
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd1);

    // Single-cycle ALU
    run_op("sra",  3'b010, 5'b01101, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1'b0, 1);
    run_op("add",  3'b000, 5'b00000, 32'd5,         32'd7,         32'd12,        1'b0, 1'b0, 1);
    run_op("sub",  3'b001, 5'b00000, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    run_op("sltu", 3'b010, 5'b00011, 32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 1'b0, 1);
    run_op("slt",  3'b010, 5'b00010, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 1);
    run_op("sll",  3'b010, 5'b00001, 32'd1,         32'h0000_0021, 32'd2,         1'b0, 1'b0, 1);
    run_op("srl",  3'b010, 5'b00101, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b0, 1);
    run_op("op4",  3'b100, 5'b00000, 32'd5,         32'd7,         32'd0,         1'b0, 1'b0, 1);

    // Multiply
    run_op("mul",    3'b010, 5'b10000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 1'b0, W + 1);
    run_op("mulh",   3'b010, 5'b10001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 1);
    run_op("mulhsu", 3'b010, 5'b10010, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 1);
    run_op("mulhu",  3'b010, 5'b10011, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 1'b0, 1'b0, W + 1);

    // Divide
`ifdef ALU_MDU_DIV_EN
    run_op("div",   3'b010, 5'b10100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, W + 1);
    run_op("rem",   3'b010, 5'b10110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, W + 1);
    run_op("divu",  3'b010, 5'b10101, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, W + 1);
    run_op("remu",  3'b010, 5'b10111, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, W + 1);
    run_op("div0",  3'b010, 5'b10100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    run_op("remu0", 3'b010, 5'b10111, 32'd7,         32'd0,         32'd7,         1'b0, 1'b1, 1);
    run_op("divov", 3'b010, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
    run_op("remov", 3'b010, 5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 1'b0, 1);
`else
    run_op("div",   3'b010, 5'b10100, 32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 1'b0, 1);
    run_op("div0",  3'b010, 5'b10100, 32'd5,         32'd0,         32'd0, 1'b0, 1'b0, 1);
    run_op("divov", 3'b010, 5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1);
`endif

    // Branch compare
    run_op("blt",  3'b011, 5'b00100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    run_op("bltu", 3'b011, 5'b00110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run_op("bf2",  3'b011, 5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1);
    run_op("beq",  3'b011, 5'b00000, 32'd5,         32'd5, 32'd0, 1'b1, 1'b0, 1);
    run_op("bgeu", 3'b011, 5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);

    // Output stall: result and valid hold, no new accept
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    launch("stall", 3'b000, 5'b00000, 32'd1, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_res", bus.aluResult, 32'd2);
      chk("stall_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    run_op("post_stall", 3'b000, 5'b00000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    // Flush at iteration 10 of a MUL
    launch("mulfl", 3'b010, 5'b10000, 32'd7, 32'd9);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fl_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    quiet("fl_quiet", 40);

    // Flush together with in_valid drops the op
    @(negedge clk);
    bus.aluOp = 3'b000; bus.func = 5'd0; bus.dataA = 32'd2; bus.dataB = 32'd2;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("flv_hs", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    quiet("flv_quiet", 5);
    run_op("post_fl", 3'b000, 5'b00000, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1);

    // Reset mid-iteration
`ifdef ALU_MDU_DIV_EN
    launch("divrst", 3'b010, 5'b10101, 32'd100, 32'd7);
`else
    launch("divrst", 3'b010, 5'b10000, 32'd100, 32'd7);
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_res", bus.aluResult, 32'd0);
    chk("mrst_ctl", {28'd0, bus.out_valid, bus.in_ready, bus.branchTaken, bus.divByZero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet("mrst_quiet", 40);
    chk("mrst_rdy", {31'd0, bus.in_ready}, 32'd1);
    run_op("post_rst", 3'b010, 5'b10011, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, W + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
